// File: rtl/alu_arb_pkg.sv
// Shared types, opcodes and the opcode legality helper for the shared-ALU arbiter.
// Consumed by alu, alu_rr_arb and alu_share_arb.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_e;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic is_legal_op(input logic [2:0] f);
        return f inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT};
    endfunction

endpackage

// File: rtl/alu.sv
// Team 32-bit ALU: f[2] inverts b and supplies the carry-in, f[1:0] picks AND/OR/SUM/SLT.
// SLT is the raw sign of the sum, with no overflow correction.
module alu
    import alu_arb_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  f,
    output logic [31:0] y,
    output logic        zero
);

    logic [31:0] b_eff;
    logic [31:0] sum;

    assign b_eff = f[2] ? ~b : b;
    assign sum   = a + b_eff + {31'b0, f[2]};

    always_comb begin
        case (f[1:0])
            ALU_AND[1:0]: y = a & b_eff;
            ALU_OR[1:0]:  y = a | b_eff;
            ALU_ADD[1:0]: y = sum;
            default:      y = {31'b0, sum[31]};
        endcase
    end

    assign zero = (y == 32'd0);

endmodule

// File: rtl/alu_rr_arb.sv
// Combinational round-robin picker: first asserted req at or above ptr, wrapping modulo NREQ.
module alu_rr_arb #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any_gnt
);

    always_comb begin
        logic [IDW-1:0] idx;
        // NOTE: every output gets a default before the search loop so no path can infer a latch.
        gnt_onehot = '0;
        gnt_idx    = '0;
        any_gnt    = 1'b0;
        idx        = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!any_gnt && req[idx]) begin
                any_gnt         = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one ALU among NREQ requesters with valid/ready request and response.
// Optional opcode checking (rsp_err port) is enabled by defining ALU_ARB_OPCHK_EN.
module alu_share_arb
    import alu_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_a,
    input  logic [NREQ-1:0][31:0] req_b,
    input  logic [NREQ-1:0][2:0]  req_f,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_y,
    output logic                  rsp_zero,
    output logic [IDW-1:0]        rsp_id
`ifdef ALU_ARB_OPCHK_EN
    ,
    output logic                  rsp_err
`endif
);

    arb_state_e     state_q;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]    op_a_q, op_b_q;
    logic [2:0]     op_f_q;
    logic [IDW-1:0] op_id_q;
    logic           rsp_valid_q, rsp_zero_q;
    logic [31:0]    rsp_y_q;
    logic [IDW-1:0] rsp_id_q;

    logic [NREQ-1:0] gnt_onehot;
    logic [IDW-1:0]  gnt_idx;
    logic            any_gnt;
    logic [31:0]     alu_y, res_y;
    logic            alu_zero, res_zero;

    alu_rr_arb #(.NREQ(NREQ)) u_arb (
        .req        (req_valid),
        .ptr        (rr_ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any_gnt    (any_gnt)
    );

    alu u_alu (
        .a    (op_a_q),
        .b    (op_b_q),
        .f    (op_f_q),
        .y    (alu_y),
        .zero (alu_zero)
    );

    // Ready is withheld during reset so an asserted valid cannot look accepted.
    assign req_ready = (state_q == IDLE && !reset) ? gnt_onehot : '0;
    assign rr_ptr_d  = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + IDW'(1);

`ifdef ALU_ARB_OPCHK_EN
    logic res_err, rsp_err_q;

    always_comb begin
        res_y    = alu_y;
        res_zero = alu_zero;
        res_err  = 1'b0;
        if (!is_legal_op(op_f_q)) begin
            res_y    = '0;
            res_zero = 1'b1;
            res_err  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err_q <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_err_q <= res_err;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign res_y    = alu_y;
    assign res_zero = alu_zero;
`endif

    // NOTE: state and every registered output update with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_f_q      <= '0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_gnt) begin
                        op_a_q   <= req_a[gnt_idx];
                        op_b_q   <= req_b[gnt_idx];
                        op_f_q   <= req_f[gnt_idx];
                        op_id_q  <= gnt_idx;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y_q     <= res_y;
                    rsp_zero_q  <= res_zero;
                    rsp_id_q    <= op_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_id    = rsp_id_q;

endmodule
